// File: rtl/hazard_ctrl.sv
// hazard_ctrl: Tuse/Tnew data-hazard and mult/div busy stall controller
// with a saturating stall-cycle counter for performance debug.
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic        D_is_md,
  input  logic [4:0]  E_A3,
  input  logic        E_RegWrite,
  input  logic [1:0]  E_Tnew,
  input  logic [4:0]  M_A3,
  input  logic        M_RegWrite,
  input  logic [1:0]  M_Tnew,
  input  logic        md_start,
  input  logic        md_is_div,
  output logic        PC_EN,
  output logic        IFID_EN,
  output logic        NOP_CLR,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_done_q, md_done_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic             stall_rs, stall_rt, stall_md, stall;

  always_comb begin
    stall_rs = (D_rs != 5'd0) &&
               ((E_RegWrite && E_A3 == D_rs && D_Tuse_rs < E_Tnew) ||
                (M_RegWrite && M_A3 == D_rs && D_Tuse_rs < M_Tnew));
    stall_rt = (D_rt != 5'd0) &&
               ((E_RegWrite && E_A3 == D_rt && D_Tuse_rt < E_Tnew) ||
                (M_RegWrite && M_A3 == D_rt && D_Tuse_rt < M_Tnew));
    md_busy  = md_start | (cnt_q != '0);
    stall_md = D_is_md & md_busy;
    stall    = (stall_rs | stall_rt | stall_md) & ~reset;
    PC_EN    = ~stall;
    IFID_EN  = ~stall;
    NOP_CLR  = stall;
    // a start is only accepted when idle; otherwise the counter just drains
    cnt_d = reset ? '0 :
            (md_start && cnt_q == '0) ? (md_is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC)) :
            (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    md_done_d   = ~reset & (cnt_q == CNT_W'(1));
    stall_cnt_d = reset ? 16'd0 :
                  (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    md_done   = md_done_q;
    stall_cnt = stall_cnt_q;
  end

  always_ff @(posedge CLK) begin
    cnt_q       <= cnt_d;
    md_done_q   <= md_done_d;
    stall_cnt_q <= stall_cnt_d;
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed literal checks plus randomized stimulus compared
// every cycle against a cycle-indexed behavioural model.
module tb_hazard_ctrl;
  logic        CLK = 0, reset = 1;
  logic [4:0]  D_rs, D_rt, E_A3, M_A3;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic        D_is_md, E_RegWrite, M_RegWrite, md_start, md_is_div;
  logic        PC_EN, IFID_EN, NOP_CLR, md_busy, md_done;
  logic [15:0] stall_cnt;

  int nvec = 0, nerr = 0;
  bit chk_en = 0;
  int cyc = 0, done_at = -1, scnt = 0;

  hazard_ctrl dut (
    .CLK(CLK), .reset(reset), .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs),
    .D_Tuse_rt(D_Tuse_rt), .D_is_md(D_is_md), .E_A3(E_A3), .E_RegWrite(E_RegWrite),
    .E_Tnew(E_Tnew), .M_A3(M_A3), .M_RegWrite(M_RegWrite), .M_Tnew(M_Tnew),
    .md_start(md_start), .md_is_div(md_is_div), .PC_EN(PC_EN), .IFID_EN(IFID_EN),
    .NOP_CLR(NOP_CLR), .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", n, cyc, a, e);
    end
  endtask

  // model: the unit is busy until cycle done_at; remaining busy cycles = done_at - cyc
  function automatic int rem();
    return done_at > cyc ? done_at - cyc : 0;
  endfunction

  function automatic bit dep(input logic [4:0] r, input logic [1:0] tu);
    int u = int'(tu);
    bit e = E_RegWrite && E_A3 == r && u < int'(E_Tnew);
    bit m = M_RegWrite && M_A3 == r && u < int'(M_Tnew);
    return r != 0 && (e || m);
  endfunction

  function automatic bit exp_busy();
    return md_start || rem() != 0;
  endfunction

  function automatic bit exp_stall();
    return !reset && (dep(D_rs, D_Tuse_rs) || dep(D_rt, D_Tuse_rt) || (D_is_md && exp_busy()));
  endfunction

  always @(posedge CLK) begin
    if (reset) begin
      done_at <= -1;
      scnt    <= 0;
    end else begin
      if (exp_stall()) scnt <= scnt < 65535 ? scnt + 1 : 65535;
      if (md_start && rem() == 0) done_at <= cyc + 1 + (md_is_div ? 10 : 5);
    end
    cyc <= cyc + 1;
  end

  always @(negedge CLK) if (chk_en) begin
    chk("PC_EN", 16'(PC_EN), 16'(!exp_stall()));
    chk("IFID_EN", 16'(IFID_EN), 16'(!exp_stall()));
    chk("NOP_CLR", 16'(NOP_CLR), 16'(exp_stall()));
    chk("md_busy", 16'(md_busy), 16'(exp_busy()));
    chk("md_done", 16'(md_done), 16'(done_at == cyc));
    chk("stall_cnt", stall_cnt, 16'(scnt));
  end

  task automatic clr();
    {D_rs, D_rt, E_A3, M_A3} = '0;
    {D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew} = '0;
    {D_is_md, E_RegWrite, M_RegWrite, md_start, md_is_div} = '0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    clr();
    step();
    step();
    reset = 0;
  endtask

  initial begin
    int busy_n, done_n, done_i;
    clr();
    step();
    chk_en = 1;
    // reset masks a live hazard and clears state
    E_RegWrite = 1; E_A3 = 1; E_Tnew = 2; D_rs = 1;
    @(negedge CLK);
    chk("rst_pc_en", 16'(PC_EN), 16'd1);
    chk("rst_nop", 16'(NOP_CLR), 16'd0);
    chk("rst_cnt", stall_cnt, 16'd0);
    chk("rst_done", 16'(md_done), 16'd0);
    do_reset();
    // load-use in E, then resolved one stage later in M
    E_RegWrite = 1; E_A3 = 1; E_Tnew = 2; D_rs = 1; D_Tuse_rs = 1;
    @(negedge CLK);
    chk("t1_nop", 16'(NOP_CLR), 16'd1);
    chk("t1_pc", 16'(PC_EN), 16'd0);
    chk("t1_ifid", 16'(IFID_EN), 16'd0);
    step();
    E_RegWrite = 0; M_RegWrite = 1; M_A3 = 1; M_Tnew = 1;
    @(negedge CLK);
    chk("t1_nop2", 16'(NOP_CLR), 16'd0);
    chk("t1_cnt", stall_cnt, 16'd1);
    do_reset();
    E_RegWrite = 1; E_A3 = 0; E_Tnew = 2; D_rs = 0; D_Tuse_rs = 1;
    @(negedge CLK);
    chk("t2_r0", 16'(NOP_CLR), 16'd0);
    step();
    E_A3 = 1; D_rs = 1; D_Tuse_rs = 3;
    @(negedge CLK);
    chk("t2_nouse", 16'(NOP_CLR), 16'd0);
    step();
    clr();
    M_RegWrite = 1; M_A3 = 5; M_Tnew = 1; D_rt = 5; D_Tuse_rt = 0;
    @(negedge CLK);
    chk("t2_m_rt", 16'(NOP_CLR), 16'd1);
    // mult: 6 busy/stall cycles, one done pulse right after
    do_reset();
    md_start = 1; D_is_md = 1;
    busy_n = 0; done_n = 0; done_i = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      busy_n += int'(md_busy && NOP_CLR);
      if (md_done) begin done_n++; done_i = i; end
      step();
      md_start = 0;
    end
    chk("t3_busy", 16'(busy_n), 16'd6);
    chk("t3_done_n", 16'(done_n), 16'd1);
    chk("t3_done_i", 16'(done_i), 16'd6);
    chk("t3_cnt", stall_cnt, 16'd6);
    // div aborted by reset when cnt=4
    do_reset();
    md_start = 1; md_is_div = 1;
    step();
    md_start = 0;
    repeat (6) step();
    @(negedge CLK);
    chk("t4_busy_pre", 16'(md_busy), 16'd1);
    reset = 1;
    step();
    reset = 0;
    @(negedge CLK);
    chk("t4_busy_post", 16'(md_busy), 16'd0);
    done_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      done_n += int'(md_done);
      step();
    end
    chk("t4_done", 16'(done_n), 16'd0);
    chk("t4_cnt", stall_cnt, 16'd0);
    // restart while cnt=3 is ignored
    do_reset();
    md_start = 1;
    step();
    md_start = 0;
    step();
    step();
    md_start = 1; md_is_div = 1;
    @(negedge CLK);
    step();
    md_start = 0;
    busy_n = 0; done_n = 0; done_i = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      busy_n += int'(md_busy);
      if (md_done) begin done_n++; done_i = i; end
      step();
    end
    chk("t5_busy", 16'(busy_n), 16'd2);
    chk("t5_done_n", 16'(done_n), 16'd1);
    chk("t5_done_i", 16'(done_i), 16'd2);
    // saturation
    do_reset();
    E_RegWrite = 1; E_A3 = 1; E_Tnew = 2; D_rs = 1; D_Tuse_rs = 0;
    repeat (65540) step();
    @(negedge CLK);
    chk("t6_sat", stall_cnt, 16'hFFFF);
    clr();
    repeat (3) step();
    @(negedge CLK);
    chk("t6_hold", stall_cnt, 16'hFFFF);
    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      D_rs = 5'($urandom_range(0, 3)); D_rt = 5'($urandom_range(0, 3));
      E_A3 = 5'($urandom_range(0, 3)); M_A3 = 5'($urandom_range(0, 3));
      D_Tuse_rs = 2'($urandom); D_Tuse_rt = 2'($urandom);
      E_Tnew = 2'($urandom); M_Tnew = 2'($urandom);
      E_RegWrite = 1'($urandom); M_RegWrite = 1'($urandom);
      D_is_md = 1'($urandom);
      md_start = $urandom_range(0, 7) == 0;
      md_is_div = 1'($urandom);
      reset = $urandom_range(0, 99) == 0;
      step();
    end
    reset = 0;
    clr();
    @(negedge CLK);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
